// File: rtl/hough_accumulator_if.sv
// Vote-write and peak-report bundle between the Hough voter, the accumulator and the overlay logic.
interface hough_accumulator_if #(
    parameter int COUNT_W = 10
);
    logic               write_enable;
    logic signed [10:0] address;
    logic [7:0]         theta;
    logic               frame_done;
    logic               ready;
    logic               vote_drop;
    logic               peak_valid;
    logic signed [10:0] peak_rho;
    logic [7:0]         peak_theta;
    logic [COUNT_W-1:0] peak_votes;

    modport master (
        output write_enable, address, theta, frame_done,
        input  ready, vote_drop, peak_valid, peak_rho, peak_theta, peak_votes
    );

    modport slave (
        input  write_enable, address, theta, frame_done,
        output ready, vote_drop, peak_valid, peak_rho, peak_theta, peak_votes
    );
endinterface

// File: rtl/hough_accumulator.sv
// Hough vote accumulator: pipelined read-modify-write voting, then a clear-on-read scan
// that reports the single strongest (rho, theta) cell of the frame.
module hough_accumulator #(
    parameter int RHO_MAX    = 800,
    parameter int THETA_BINS = 180,
    parameter int COUNT_W    = 10,
    parameter int ADDR_W     = 19
) (
    input  logic          i_clock,
    input  logic          i_reset,
    hough_accumulator_if.slave io_vote
);
    localparam int RHO_BINS = 2 * RHO_MAX + 1;
    localparam int DEPTH    = RHO_BINS * THETA_BINS;
    localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]         CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]         LAST_IDX   = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]         DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic signed [10:0]      RHO_HI     = 11'(RHO_MAX);
    localparam logic signed [10:0]      RHO_LO     = 11'(-RHO_MAX);
    localparam logic [10:0]             RHO_OFF    = 11'(RHO_MAX);
    localparam logic [10:0]             RHO_LAST   = 11'(RHO_BINS - 1);
    localparam logic [7:0]              THETA_LIM  = 8'(THETA_BINS);
    localparam logic [ADDR_W-1:0]       RHO_BINS_A = ADDR_W'(RHO_BINS);
    localparam logic [COUNT_W-1:0]      CNT_MAX    = '1;

    typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_SCAN, S_REPORT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_ready;
    logic                w_peak_valid;

    logic [ADDR_W:0]     r_cnt;
    logic                r_vote_drop;
    logic                r_s1_vld;
    logic [ADDR_W-1:0]   r_s1_idx;
    logic                r_s2_vld;
    logic                r_scan_rd_vld;
    logic                r_fwd_vld;
    logic [ADDR_W-1:0]   r_fwd_idx;
    logic [COUNT_W-1:0]  r_fwd_data;
    logic [ADDR_W-1:0]   r_rd_idx;
    logic [COUNT_W-1:0]  r_rd_data;
    logic [COUNT_W-1:0]  r_mem [DEPTH];

    logic [10:0]         r_rho_cnt;
    logic [7:0]          r_theta_cnt;
    logic [COUNT_W-1:0]  r_max_votes;
    logic [10:0]         r_max_rho;
    logic [7:0]          r_max_theta;
    logic signed [10:0]  r_peak_rho;
    logic [7:0]          r_peak_theta;
    logic [COUNT_W-1:0]  r_peak_votes;

    logic                w_in_range;
    logic                w_accept;
    logic [10:0]         w_rho_u;
    logic [ADDR_W-1:0]   w_idx;
    logic [ADDR_W-1:0]   w_raddr;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [COUNT_W-1:0]  w_wdata;
    logic [COUNT_W-1:0]  w_rd_cur;
    logic [COUNT_W-1:0]  w_inc;
    logic                w_take;
    logic [COUNT_W-1:0]  w_fin_votes;
    logic [10:0]         w_fin_rho;
    logic [7:0]          w_fin_theta;

    assign w_in_range = (io_vote.address >= RHO_LO) && (io_vote.address <= RHO_HI)
                      && (io_vote.theta < THETA_LIM);
    assign w_accept   = w_ready && io_vote.write_enable && w_in_range;
    assign w_rho_u    = $unsigned(io_vote.address) + RHO_OFF;
    assign w_idx      = ADDR_W'(io_vote.theta) * RHO_BINS_A + ADDR_W'(w_rho_u);

    // A read that coincided with a write to the same cell returns the old value; use the written one.
    assign w_rd_cur = (r_fwd_vld && (r_fwd_idx == r_rd_idx)) ? r_fwd_data : r_rd_data;
    assign w_inc    = (w_rd_cur == CNT_MAX) ? w_rd_cur : w_rd_cur + COUNT_W'(1);
    assign w_raddr  = (r_state == S_SCAN) ? r_cnt[ADDR_W-1:0] : r_s1_idx;

    assign w_take      = r_scan_rd_vld && (w_rd_cur > r_max_votes);
    assign w_fin_votes = w_take ? w_rd_cur    : r_max_votes;
    assign w_fin_rho   = w_take ? r_rho_cnt   : r_max_rho;
    assign w_fin_theta = w_take ? r_theta_cnt : r_max_theta;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_peak_valid = 1'b0;
        unique case (r_state)
            S_CLEAR:  if (r_cnt == LAST_IDX) w_state_next = S_ACCUM;
            S_ACCUM: begin
                w_ready = 1'b1;
                if (io_vote.frame_done) w_state_next = S_DRAIN;
            end
            S_DRAIN:  if (r_cnt == CNT_ONE) w_state_next = S_SCAN;
            S_SCAN:   if (r_cnt == DEPTH_C) w_state_next = S_REPORT;
            S_REPORT: begin
                w_peak_valid = 1'b1;
                w_state_next = S_ACCUM;
            end
            default:  w_state_next = S_CLEAR;
        endcase
    end

    // Single write port shared by the clear sweep, the scan's clear-behind and the vote increment.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (r_state == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[ADDR_W-1:0];
        end else if (r_scan_rd_vld) begin
            w_we    = 1'b1;
            w_waddr = r_rd_idx;
        end else if (r_s2_vld) begin
            w_we    = 1'b1;
            w_waddr = r_rd_idx;
            w_wdata = w_inc;
        end
    end

    // NOTE: the RAM has no reset; the CLEAR sweep zeroes it instead, which keeps it mappable to block RAM.
    always_ff @(posedge i_clock) begin
        if (w_we) r_mem[w_waddr[MEM_AW-1:0]] <= w_wdata;
        r_rd_data <= r_mem[w_raddr[MEM_AW-1:0]];
        r_rd_idx  <= w_raddr;
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt         <= '0;
            r_vote_drop   <= 1'b0;
            r_s1_vld      <= 1'b0;
            r_s1_idx      <= '0;
            r_s2_vld      <= 1'b0;
            r_scan_rd_vld <= 1'b0;
            r_fwd_vld     <= 1'b0;
            r_fwd_idx     <= '0;
            r_fwd_data    <= '0;
            r_rho_cnt     <= '0;
            r_theta_cnt   <= '0;
            r_max_votes   <= '0;
            r_max_rho     <= '0;
            r_max_theta   <= '0;
            r_peak_rho    <= '0;
            r_peak_theta  <= '0;
            r_peak_votes  <= '0;
        end else begin
            r_cnt         <= (w_state_next != r_state) ? '0 : r_cnt + CNT_ONE;
            r_vote_drop   <= io_vote.write_enable && !w_accept;
            r_s1_vld      <= w_accept;
            r_s1_idx      <= w_idx;
            r_s2_vld      <= r_s1_vld;
            r_scan_rd_vld <= (r_state == S_SCAN) && (r_cnt < DEPTH_C);
            r_fwd_vld     <= w_we;
            r_fwd_idx     <= w_waddr;
            r_fwd_data    <= w_wdata;

            if (r_state != S_SCAN) begin
                r_rho_cnt   <= '0;
                r_theta_cnt <= '0;
                r_max_votes <= '0;
                r_max_rho   <= '0;
                r_max_theta <= '0;
            end else if (r_scan_rd_vld) begin
                r_max_votes <= w_fin_votes;
                r_max_rho   <= w_fin_rho;
                r_max_theta <= w_fin_theta;
                if (r_rho_cnt == RHO_LAST) begin
                    r_rho_cnt   <= '0;
                    r_theta_cnt <= r_theta_cnt + 8'(1);
                end else begin
                    r_rho_cnt <= r_rho_cnt + 11'(1);
                end
            end

            if ((r_state == S_SCAN) && (w_state_next == S_REPORT)) begin
                r_peak_votes <= w_fin_votes;
                r_peak_rho   <= $signed(w_fin_rho - RHO_OFF);
                r_peak_theta <= w_fin_theta;
            end
        end
    end

    assign io_vote.ready      = w_ready;
    assign io_vote.vote_drop  = r_vote_drop;
    assign io_vote.peak_valid = w_peak_valid;
    assign io_vote.peak_rho   = r_peak_rho;
    assign io_vote.peak_theta = r_peak_theta;
    assign io_vote.peak_votes = r_peak_votes;
endmodule

// File: tb/tb_hough_accumulator.sv
// Directed and randomized frames against an array-of-counts model of the Hough accumulator.
module tb_hough_accumulator;
    localparam int RM    = 4;
    localparam int TB    = 4;
    localparam int CW    = 3;
    localparam int AW    = 6;
    localparam int RB    = 2 * RM + 1;
    localparam int DEPTH = RB * TB;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_ready = 1'b0;
    int   model [DEPTH];

    hough_accumulator_if #(.COUNT_W(CW)) vif ();

    hough_accumulator #(
        .RHO_MAX(RM), .THETA_BINS(TB), .COUNT_W(CW), .ADDR_W(AW)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .io_vote(vif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input int rho, input int th);
        return (rho >= -RM) && (rho <= RM) && (th >= 0) && (th < TB);
    endfunction

    // One clock of stimulus: the model takes the vote if the block should be accepting it.
    task automatic step(input bit we, input int rho, input int th, input bit fd);
        bit acc;
        int idx;
        vif.write_enable = we;
        vif.address      = 11'(rho);
        vif.theta        = 8'(th);
        vif.frame_done   = fd;
        check("ready", 32'(vif.ready), 32'(exp_ready));
        acc = we && exp_ready && in_range(rho, th);
        if (acc) begin
            idx = th * RB + rho + RM;
            if (model[idx] < CMAX) model[idx]++;
        end
        @(negedge clk);
        check("vote_drop", 32'(vif.vote_drop), 32'(we && !acc));
        vif.write_enable = 1'b0;
        vif.frame_done   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(vif.ready), 0);
        check("rst_peak_valid", 32'(vif.peak_valid), 0);
        check("rst_vote_drop", 32'(vif.vote_drop), 0);
        check("rst_peak_votes", 32'(vif.peak_votes), 0);
        check("rst_peak_rho", 32'($signed(vif.peak_rho)), 0);
        check("rst_peak_theta", 32'(vif.peak_theta), 0);
        rst = 1'b0;
        exp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        repeat (DEPTH) step(1'b0, 0, 0, 1'b0);
        exp_ready = 1'b1;
    endtask

    // Called on the cycle after frame_done; optionally presents one vote while the scan runs.
    task automatic wait_report(input int inject_at);
        int n;
        bit seen;
        int best;
        int ev;
        int er;
        int et;
        n = 1;
        seen = 1'b0;
        while (!seen && n < DEPTH + 12) begin
            if (vif.peak_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                step(n == inject_at, 0, 0, 1'b0);
                n++;
            end
        end
        check("report_seen", 32'(seen), 1);
        check("report_latency", n, DEPTH + 4);
        best = 0;
        for (int i = 1; i < DEPTH; i++) if (model[i] > model[best]) best = i;
        ev = model[best];
        er = (best % RB) - RM;
        et = best / RB;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        check("peak_votes", 32'(vif.peak_votes), ev);
        check("peak_rho", 32'($signed(vif.peak_rho)), er);
        check("peak_theta", 32'(vif.peak_theta), et);
        step(1'b0, 0, 0, 1'b0);
        check("peak_valid_pulse", 32'(vif.peak_valid), 0);
        check("peak_votes_hold", 32'(vif.peak_votes), ev);
        exp_ready = 1'b1;
    endtask

    task automatic end_frame(input bit we, input int rho, input int th, input int inject_at);
        step(we, rho, th, 1'b1);
        exp_ready = 1'b0;
        wait_report(inject_at);
    endtask

    initial begin
        int rho;
        int th;
        int r;
        vif.write_enable = 1'b0;
        vif.address      = '0;
        vif.theta        = '0;
        vif.frame_done   = 1'b0;
        do_reset();
        step(1'b0, 0, 0, 1'b0);

        end_frame(1'b0, 0, 0, -1);

        repeat (3) step(1'b1, 2, 1, 1'b0);
        step(1'b1, -1, 3, 1'b0);
        end_frame(1'b0, 0, 0, -1);

        repeat (9) step(1'b1, 0, 0, 1'b0);
        end_frame(1'b0, 0, 0, -1);

        step(1'b1, 1, 0, 1'b0);
        step(1'b1, -3, 2, 1'b0);
        step(1'b1, 1, 0, 1'b0);
        step(1'b1, -3, 2, 1'b0);
        end_frame(1'b0, 0, 0, -1);

        step(1'b1, 5, 0, 1'b0);
        step(1'b1, 0, 4, 1'b0);
        step(1'b1, -5, 1, 1'b0);
        end_frame(1'b0, 0, 0, 10);
        step(1'b1, 3, 3, 1'b0);
        end_frame(1'b0, 0, 0, -1);

        step(1'b1, 2, 2, 1'b0);
        step(1'b1, 2, 2, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        exp_ready = 1'b0;
        repeat (15) step(1'b0, 0, 0, 1'b0);
        do_reset();
        check("post_clear_peak_valid", 32'(vif.peak_valid), 0);
        check("post_clear_peak_votes", 32'(vif.peak_votes), 0);
        step(1'b1, -4, 0, 1'b0);
        end_frame(1'b0, 0, 0, -1);

        // Random frames: frequent repeats of the previous cell stress forwarding and saturation.
        rho = 0;
        th  = 0;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 40; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 2) begin
                    step(1'b0, 0, 0, 1'b0);
                end else begin
                    if (r >= 6) begin
                        rho = int'($urandom_range(0, 2 * RM + 2)) - RM - 1;
                        th  = int'($urandom_range(0, TB));
                    end
                    step(1'b1, rho, th, 1'b0);
                end
            end
            end_frame(1'b1, rho, th, int'($urandom_range(3, 30)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
